// File: rtl/flow_mux_ms.sv
// Per-flow input FIFOs feeding a round-robin arbiter that emits {flow tag, pel} words.
// Define FLOW_MUX_STATS_EN to add the per-flow saturating grant_cnt output.
module flow_mux_ms #(
    parameter int DEPTH  = 16,
    parameter int FLUX   = 4,
    parameter int DATA_W = 8,
    parameter int TAG_W  = $clog2(FLUX)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLUX-1:0]         in_write,
    input  logic [FLUX*DATA_W-1:0]  in_din,
    output logic [FLUX-1:0]         in_full,
    output logic [FLUX-1:0]         in_ovf,
    output logic                    out_write,
    output logic [TAG_W+DATA_W-1:0] out_din,
    input  logic [FLUX-1:0]         out_full
`ifdef FLOW_MUX_STATS_EN
    ,
    output logic [FLUX*16-1:0]      grant_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem  [FLUX][DEPTH];
    logic [AW-1:0]     r_wptr [FLUX];
    logic [AW-1:0]     r_rptr [FLUX];
    logic [AW:0]       r_cnt  [FLUX];
    logic [FLUX-1:0]   r_ovf;
    logic [TAG_W-1:0]  r_last;
    logic              r_out_write;
    logic [TAG_W+DATA_W-1:0] r_out_din;

    logic [FLUX-1:0]   w_full;
    logic [FLUX-1:0]   w_elig;
    logic [FLUX-1:0]   w_push;
    logic [FLUX-1:0]   w_pop;
    logic              w_grant_vld;
    logic [TAG_W-1:0]  w_grant;

    // Full and eligibility come only from registered counts, so nothing written this cycle is visible.
    always_comb begin
        w_full = '0;
        w_elig = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            w_full[i] = (r_cnt[i] == (AW+1)'(DEPTH));
            w_elig[i] = (r_cnt[i] != '0) && !out_full[i];
        end
    end

    always_comb begin
        logic [TAG_W-1:0] cand;
        cand        = '0;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int unsigned off = 0; off < FLUX; off++) begin
            cand = r_last + TAG_W'(off + 1);
            if (!w_grant_vld && w_elig[cand]) begin
                w_grant_vld = 1'b1;
                w_grant     = cand;
            end
        end
    end

    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            w_push[i] = in_write[i] && !w_full[i];
            w_pop[i]  = w_grant_vld && (w_grant == TAG_W'(i));
        end
    end

    // Storage carries no reset; emptiness is tracked entirely by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (w_push[i]) r_mem[i][r_wptr[i]] <= in_din[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_ovf       <= '0;
            r_last      <= TAG_W'(FLUX - 1);
            r_out_write <= 1'b0;
            r_out_din   <= '0;
        end else begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
                if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
                if (in_write[i] && w_full[i]) r_ovf[i] <= 1'b1;
            end
            r_out_write <= w_grant_vld;
            if (w_grant_vld) begin
                r_out_din <= {w_grant, r_mem[w_grant][r_rptr[w_grant]]};
                r_last    <= w_grant;
            end
        end
    end

    assign in_full   = w_full;
    assign in_ovf    = r_ovf;
    assign out_write = r_out_write;
    assign out_din   = r_out_din;

`ifdef FLOW_MUX_STATS_EN
    logic [15:0] r_gcnt [FLUX];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (rst)                               r_gcnt[i] <= '0;
            else if (w_pop[i] && r_gcnt[i] != '1)  r_gcnt[i] <= r_gcnt[i] + 1'b1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < FLUX; i++) grant_cnt[i*16 +: 16] = r_gcnt[i];
    end
`endif
endmodule

// File: tb/tb_flow_mux_ms.sv
// Directed and randomized bench for flow_mux_ms against a queue-based reference model.
module tb_flow_mux_ms;
    localparam int DEPTH  = 16;
    localparam int FLUX   = 4;
    localparam int DATA_W = 8;
    localparam int TAG_W  = $clog2(FLUX);
    localparam int OW     = TAG_W + DATA_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [FLUX-1:0]        in_write = '0;
    logic [FLUX*DATA_W-1:0] in_din = '0;
    logic [FLUX-1:0]        in_full;
    logic [FLUX-1:0]        in_ovf;
    logic                   out_write;
    logic [OW-1:0]          out_din;
    logic [FLUX-1:0]        out_full = '0;
`ifdef FLOW_MUX_STATS_EN
    logic [FLUX*16-1:0]     grant_cnt;
`endif

    flow_mux_ms #(.DEPTH(DEPTH), .FLUX(FLUX), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_write  (in_write),
        .in_din    (in_din),
        .in_full   (in_full),
        .in_ovf    (in_ovf),
        .out_write (out_write),
        .out_din   (out_din),
        .out_full  (out_full)
`ifdef FLOW_MUX_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: one queue per flow plus the round-robin pointer.
    logic [DATA_W-1:0] q [FLUX][$];
    int                m_last;
    logic [FLUX-1:0]   m_ovf;
    logic              exp_w;
    logic [OW-1:0]     exp_d;
    int                grants [FLUX];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int f = 0; f < FLUX; f++) begin
            q[f].delete();
            grants[f] = 0;
        end
        m_last = FLUX - 1;
        m_ovf  = '0;
        exp_w  = 1'b0;
        exp_d  = '0;
    endtask

    function automatic logic [FLUX-1:0] exp_full();
        logic [FLUX-1:0] v;
        v = '0;
        for (int f = 0; f < FLUX; f++) v[f] = (q[f].size() == DEPTH);
        return v;
    endfunction

    // One clock: model predicts from the pre-edge state and current inputs, then the DUT is compared.
    task automatic step();
        int g;
        logic [FLUX-1:0] was_full;
        g = -1;
        was_full = exp_full();
        for (int k = 1; k <= FLUX; k++) begin
            int f;
            f = (m_last + k) % FLUX;
            if (g < 0 && q[f].size() > 0 && !out_full[f]) g = f;
        end
        if (g >= 0) begin
            exp_w  = 1'b1;
            exp_d  = {TAG_W'(g), q[g].pop_front()};
            m_last = g;
            grants[g]++;
        end else begin
            exp_w = 1'b0;
        end
        for (int f = 0; f < FLUX; f++) begin
            if (in_write[f]) begin
                if (was_full[f]) m_ovf[f] = 1'b1;
                else q[f].push_back(in_din[f*DATA_W +: DATA_W]);
            end
        end
        @(posedge clk);
        #1;
        check("out_write", 64'(out_write), 64'(exp_w));
        check("out_din",   64'(out_din),   64'(exp_d));
        check("in_full",   64'(in_full),   64'(exp_full()));
        check("in_ovf",    64'(in_ovf),    64'(m_ovf));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_out_write", 64'(out_write), 64'(0));
        check("rst_out_din",   64'(out_din),   64'(0));
        check("rst_in_full",   64'(in_full),   64'(0));
        check("rst_in_ovf",    64'(in_ovf),    64'(0));
        rst      = 1'b0;
        in_write = '0;
    endtask

    task automatic write_flow(input int f, input logic [DATA_W-1:0] d);
        in_write    = '0;
        in_write[f] = 1'b1;
        in_din[f*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        model_reset();

        // Reset state
        do_reset();

        // Single word on flow 2 appears one idle edge later
        write_flow(2, 8'h11);
        step();
        check("lat_idle", 64'(out_write), 64'(0));
        in_write = '0;
        step();
        check("lat_word", 64'(out_din), 64'(12'h211));
        step();
        check("lat_once", 64'(out_write), 64'(0));

        // Three words per flow, then 12 cycles of strict rotation
        do_reset();
        out_full = '1;
        for (int w = 0; w < 3; w++) begin
            in_write = '1;
            for (int f = 0; f < FLUX; f++) in_din[f*DATA_W +: DATA_W] = 8'(f * 16 + w);
            step();
        end
        in_write = '0;
        out_full = '0;
        for (int n = 0; n < 12; n++) begin
            step();
            check("rr_tag",  64'(out_din[OW-1 -: TAG_W]), 64'(n % FLUX));
            check("rr_data", 64'(out_din[DATA_W-1:0]), 64'((n % FLUX) * 16 + n / FLUX));
        end
`ifdef FLOW_MUX_STATS_EN
        for (int f = 0; f < FLUX; f++) check("grant_cnt", 64'(grant_cnt[f*16 +: 16]), 64'(3));
`endif

        // Fill flow 1 under backpressure, overflow on the 17th, then drain in order
        do_reset();
        out_full = 4'b0010;
        for (int n = 0; n < DEPTH; n++) begin
            write_flow(1, 8'(8'h40 + n));
            step();
        end
        check("full_after_16", 64'(in_full[1]), 64'(1));
        write_flow(1, 8'hEE);
        step();
        check("ovf_set", 64'(in_ovf[1]), 64'(1));
        in_write = '0;
        out_full = '0;
        for (int n = 0; n < DEPTH; n++) begin
            step();
            check("drain_word", 64'(out_din), 64'({2'd1, 8'(8'h40 + n)}));
        end
        step();
        check("drain_done", 64'(out_write), 64'(0));
        check("ovf_sticky", 64'(in_ovf[1]), 64'(1));

        // Flow 0 held off while the others rotate
        do_reset();
        out_full = '1;
        for (int w = 0; w < 2; w++) begin
            in_write = '1;
            for (int f = 0; f < FLUX; f++) in_din[f*DATA_W +: DATA_W] = 8'(8'h80 + f * 4 + w);
            step();
        end
        in_write = '0;
        out_full = 4'b0001;
        for (int n = 0; n < 6; n++) begin
            step();
            check("skip_tag", 64'(out_din[OW-1 -: TAG_W]), 64'(1 + n % 3));
        end

        // Reset with data buffered and a write pending, then a fresh word on flow 3
        out_full = '0;
        in_write = '1;
        do_reset();
        write_flow(3, 8'h5A);
        step();
        in_write = '0;
        step();
        check("post_rst_first", 64'(out_din), 64'({2'd3, 8'h5A}));

        // Randomized traffic, biased so FIFOs fill and wrap
        for (int n = 0; n < 3000; n++) begin
            in_write = FLUX'($urandom);
            in_din   = (FLUX*DATA_W)'($urandom);
            out_full = (n % 400 < 200) ? FLUX'($urandom & $urandom) : FLUX'($urandom | $urandom);
            step();
        end
        in_write = '0;
        out_full = '0;
        for (int n = 0; n < FLUX * DEPTH + 2; n++) step();
        check("all_drained", 64'(out_write), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
